draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameters: X_W, default 8, x coordinate width; Y_W, default 7, y coordinate width; COLOUR_W, default 3, colour width; SCREEN_W, default 160, visible columns; SCREEN_H, default 120, visible rows.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr_req  in  1  requester 0: full-screen fill.
- clr_colour  in  COLOUR_W  fill colour.
- rect_req  in  1  requester 1: rectangle draw.
- rect_x, rect_y  in  X_W, Y_W  rectangle origin.
- rect_w, rect_h  in  X_W, Y_W  rectangle size in pixels.
- rect_colour  in  COLOUR_W  rectangle colour.
- plot_ready  in  1  downstream pixel sink can accept.
- ack  out  2  one-cycle grant pulse; bit 0 is clear, bit 1 is rect.
- plot  out  1  pixel valid.
- x_out, y_out, colour_out  out  X_W, Y_W, COLOUR_W  pixel address and colour.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL implement the states IDLE, PAINT and DONE.
REQ-004 In IDLE with any request high, SHALL grant clear over rect (fixed priority), latch the granted operands, pulse the matching ack bit that same cycle, and enter PAINT on the next edge.
REQ-005 A clear SHALL latch origin (0,0), width SCREEN_W, height SCREEN_H and clr_colour.
REQ-006 Requesters SHALL hold req until ack is seen; a request still high after ack SHALL be treated as a new request on the next IDLE cycle.
REQ-007 PAINT SHALL scan in raster order (column counter fastest), driving x_out=x0+xc, y_out=y0+yc and colour_out=latched colour.
REQ-008 Counters SHALL advance only on cycles with plot_ready=1; when plot_ready=0, every output SHALL hold.
REQ-009 Sums SHALL be computed one bit wider than the coordinate; a pixel with a sum >= SCREEN_W or >= SCREEN_H SHALL be clipped (plot=0) but still consume one counter step.
REQ-010 When plot_ready=1, an unclipped pixel SHALL assert plot for exactly one cycle.
REQ-011 After the final pixel (xc=w-1, yc=h-1) steps, SHALL enter DONE; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-012 A request with w=0 or h=0 SHALL go IDLE to DONE directly, with no plot.
REQ-013 Requests arriving while busy SHALL be ignored (no ack) until IDLE.
REQ-014 With plot_ready held high, a w×h request SHALL take 1 accept cycle + w·h PAINT cycles + 1 DONE cycle.

Reset
REQ-015 Reset low SHALL asynchronously force state IDLE, all counters and latched operands to 0, and ack, plot, busy, done, x_out, y_out and colour_out to 0.
REQ-016 Reset mid-PAINT SHALL abandon the operation without a done pulse; after release, new requests SHALL be serviced normally.

Structure
REQ-017 A shared package SHALL hold the state enumeration and the default SCREEN_W, SCREEN_H and field widths.
REQ-018 SHALL instantiate exactly one sub-module, xy_counter, which provides the nested column/row counter with enable, load and last-pixel flag.

Verification
REQ-019 Reset, then rect_req with (x,y,w,h)=(10,5,3,2) and colour 5 -> ack=2'b10, then plots (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) in consecutive cycles, then done; 8 cycles total.
REQ-020 clr_req and rect_req asserted in the same cycle -> ack=2'b01, 19200 plots covering (0,0) to (159,119), done; rect_req still high -> ack=2'b10 on the next IDLE cycle.
REQ-021 Rect (158,118,4,4) -> 16 PAINT cycles, plot only for (158..159, 118..119), i.e. 4 plots.
REQ-022 Rect with w=0 -> ack, then done on the following cycle, no plot, busy high for one cycle.
REQ-023 plot_ready toggled 1,0,0,1 during a 2×1 rect -> (x0,y0) holds for the stalled cycles, exactly 2 plots, done after the second plot.
REQ-024 Reset asserted on the 3rd PAINT cycle of a clear -> outputs 0 immediately, no done; a subsequent rect completes correctly.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared types and default geometry for the draw sequencer.
package draw_sequencer_pkg;

  localparam int unsigned DEF_X_W      = 8;
  localparam int unsigned DEF_Y_W      = 7;
  localparam int unsigned DEF_COLOUR_W = 3;
  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/draw_sequencer_xy.sv
// Nested column/row counter: column runs fastest, row steps when a column wraps.
module xy_counter
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned X_W = DEF_X_W,
  parameter int unsigned Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] xc,
  output logic [Y_W-1:0] yc,
  output logic           last
);

  logic [X_W-1:0] w_q;
  logic [Y_W-1:0] h_q;
  logic [X_W:0]   xc_inc;
  logic [Y_W:0]   yc_inc;
  logic           col_last;
  logic           row_last;

  // Compare count+1 against the size so w-1 never needs a subtraction.
  assign xc_inc   = {1'b0, xc} + (X_W+1)'(1);
  assign yc_inc   = {1'b0, yc} + (Y_W+1)'(1);
  assign col_last = (xc_inc == {1'b0, w_q});
  assign row_last = (yc_inc == {1'b0, h_q});
  assign last     = col_last & row_last;

  // Size latch and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xc  <= '0;
      yc  <= '0;
      w_q <= '0;
      h_q <= '0;
    end else if (load) begin
      xc  <= '0;
      yc  <= '0;
      w_q <= w;
      h_q <= h;
    end else if (en) begin
      if (col_last) begin
        xc <= '0;
        yc <= yc_inc[Y_W-1:0];
      end else begin
        xc <= xc_inc[X_W-1:0];
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Two-requester fill/rectangle sequencer emitting one clipped pixel per accepted step.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned COLOUR_W = DEF_COLOUR_W,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_req,
  input  logic [COLOUR_W-1:0] clr_colour,
  input  logic                rect_req,
  input  logic [X_W-1:0]      rect_x,
  input  logic [Y_W-1:0]      rect_y,
  input  logic [X_W-1:0]      rect_w,
  input  logic [Y_W-1:0]      rect_h,
  input  logic [COLOUR_W-1:0] rect_colour,
  input  logic                plot_ready,
  output logic [1:0]          ack,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                busy,
  output logic                done
);

  state_t              state, state_nxt;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [COLOUR_W-1:0] col_q;
  logic [X_W-1:0]      sel_x, sel_w;
  logic [Y_W-1:0]      sel_y, sel_h;
  logic [COLOUR_W-1:0] sel_col;
  logic                load, en, last;
  logic [X_W-1:0]      xc;
  logic [Y_W-1:0]      yc;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                clipped, painting;

  xy_counter #(.X_W(X_W), .Y_W(Y_W)) u_xy (
    .clk  (clk),
    .rst_n(reset),
    .load (load),
    .en   (en),
    .w    (sel_w),
    .h    (sel_h),
    .xc   (xc),
    .yc   (yc),
    .last (last)
  );

  // Operand select: a clear overrides the rectangle and covers the whole screen.
  always_comb begin
    sel_x   = rect_x;
    sel_y   = rect_y;
    sel_w   = rect_w;
    sel_h   = rect_h;
    sel_col = rect_colour;
    if (clr_req) begin
      sel_x   = '0;
      sel_y   = '0;
      sel_w   = X_W'(SCREEN_W);
      sel_h   = Y_W'(SCREEN_H);
      sel_col = clr_colour;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, grant and counter control.
  always_comb begin
    state_nxt = state;
    ack       = '0;
    load      = 1'b0;
    en        = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Grant is combinational, so it is masked while reset is held.
        if (reset && (clr_req || rect_req)) begin
          ack       = clr_req ? 2'b01 : 2'b10;
          load      = 1'b1;
          state_nxt = ((sel_w == '0) || (sel_h == '0)) ? ST_DONE : ST_PAINT;
        end
      end
      ST_PAINT: begin
        en = plot_ready;
        if (plot_ready && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Origin and colour latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0    <= '0;
      y0    <= '0;
      col_q <= '0;
    end else if (load) begin
      x0    <= sel_x;
      y0    <= sel_y;
      col_q <= sel_col;
    end
  end

  assign sum_x      = {1'b0, x0} + {1'b0, xc};
  assign sum_y      = {1'b0, y0} + {1'b0, yc};
  assign clipped    = (sum_x >= (X_W+1)'(SCREEN_W)) || (sum_y >= (Y_W+1)'(SCREEN_H));
  assign painting   = (state == ST_PAINT);
  assign plot       = painting && !clipped && plot_ready;
  assign x_out      = painting ? sum_x[X_W-1:0] : '0;
  assign y_out      = painting ? sum_y[Y_W-1:0] : '0;
  assign colour_out = painting ? col_q : '0;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer against a pixel-list reference model.
module tb_draw_sequencer;

  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr_req = 1'b0, rect_req = 1'b0, plot_ready = 1'b0;
  logic [2:0] clr_colour = '0, rect_colour = '0;
  logic [7:0] rect_x = '0, rect_w = '0;
  logic [6:0] rect_y = '0, rect_h = '0;
  logic [1:0] ack;
  logic       plot, busy, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_sequencer #(.X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .clr_colour(clr_colour),
    .rect_req(rect_req), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w),
    .rect_h(rect_h), .rect_colour(rect_colour), .plot_ready(plot_ready),
    .ack(ack), .plot(plot), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs for the accept cycle are already driven at a falling edge.
  // mode 0: ready always 1; mode 1: random ready; mode 2: ready 0,0 then 1.
  task automatic run_op(input int ex_ack, input int ox, input int oy, input int ow,
                        input int oh, input int col, input int mode);
    logic [31:0] expq[$];
    logic [31:0] prev_out, cur_out;
    int cyc, npl, nexp, bound, stalls;
    bit seen_done, prev_paint, prev_ready;
    for (int yy = 0; yy < oh; yy++)
      for (int xx = 0; xx < ow; xx++)
        if (ox + xx < SW && oy + yy < SH)
          expq.push_back(32'((ox + xx) * 1024 + (oy + yy) * 8 + col));
    nexp = expq.size();
    bound = 8 * ow * oh + 20;
    plot_ready = 1'b1;
    #1;
    chk("accept_ack", 32'(ack), 32'(ex_ack));
    chk("accept_busy", 32'(busy), 0);
    chk("accept_done", 32'(done), 0);
    chk("accept_plot", 32'(plot), 0);
    cyc = 1; npl = 0; stalls = 0;
    seen_done = 0; prev_paint = 0; prev_ready = 1; prev_out = '0;
    while (!seen_done && cyc < bound) begin
      @(negedge clk);
      if (ex_ack == 1) clr_req = 1'b0;
      if (ex_ack == 2) rect_req = 1'b0;
      if (mode == 1)      plot_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) plot_ready = (cyc > 2);
      else                plot_ready = 1'b1;
      #1;
      cyc++;
      cur_out = 32'({x_out, y_out, colour_out});
      chk("ack_while_busy", 32'(ack), 0);
      chk("busy", 32'(busy), 1);
      if (prev_paint && !prev_ready) chk("stall_hold", cur_out, prev_out);
      if (mode == 2 && !plot_ready && !done) begin
        stalls++;
        chk("stall_xy", 32'({x_out, y_out}), 32'(ox * 128 + oy));
      end
      if (plot) begin
        npl++;
        if (expq.size() > 0) chk("pixel", cur_out, expq.pop_front());
      end
      if (done) seen_done = 1;
      prev_paint = busy && !done;
      prev_ready = plot_ready;
      prev_out   = cur_out;
    end
    chk("done_seen", 32'(seen_done), 1);
    chk("plot_count", 32'(npl), 32'(nexp));
    if (mode != 1) chk("cycles", 32'(cyc), 32'((ow * oh > 0 ? ow * oh + 2 : 2) + stalls));
  endtask

  task automatic rect(input int rx, input int ry, input int rw, input int rh,
                      input int col, input int mode);
    @(negedge clk);
    rect_x = 8'(rx); rect_y = 7'(ry); rect_w = 8'(rw); rect_h = 7'(rh);
    rect_colour = 3'(col);
    rect_req = 1'b1;
    run_op(2, rx, ry, rw, rh, col, mode);
  endtask

  initial begin
    // Reset with a request pending: nothing may be granted.
    rect_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_xyc", 32'({x_out, y_out, colour_out}), 0);
    @(negedge clk);
    rect_req = 1'b0;
    reset = 1'b1;

    // Basic rectangle.
    rect(10, 5, 3, 2, 5, 0);

    // Clear and rect together: clear wins, rect served on the next idle cycle.
    @(negedge clk);
    rect_x = 8'd30; rect_y = 7'd40; rect_w = 8'd2; rect_h = 7'd2; rect_colour = 3'd6;
    clr_colour = 3'd2;
    clr_req = 1'b1;
    rect_req = 1'b1;
    run_op(1, 0, 0, SW, SH, 2, 0);
    @(negedge clk);
    run_op(2, 30, 40, 2, 2, 6, 0);

    // Corner clipping.
    rect(158, 118, 4, 4, 1, 0);

    // Zero-size requests.
    rect(20, 20, 0, 3, 4, 0);
    rect(20, 20, 5, 0, 4, 0);

    // Stall pattern on a 2x1 rectangle.
    rect(50, 60, 2, 1, 7, 2);

    // Reset on the third paint cycle of a clear.
    @(negedge clk);
    clr_colour = 3'd3;
    clr_req = 1'b1;
    plot_ready = 1'b1;
    #1;
    chk("clr2_ack", 32'(ack), 1);
    @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_x", 32'(x_out), 2);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(plot), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_xyc", 32'({x_out, y_out, colour_out}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_done", 32'(done), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    rect(100, 100, 4, 3, 3, 0);

    // Randomised rectangles, some with random back-pressure.
    for (int n = 0; n < 14; n++)
      rect($urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 12),
           $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 1));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
